// File: rtl/fetch_wait_stage_if.sv
// fetch_wait_stage_if: fetch/memory/decode signals of the IF_wait stage.
//   slave  : the stage's view. It takes the fetch entry, the memory response, the flush
//            and the decode ready, and returns ready_o, the registered entry and perfcnt.
//   master : the environment's view, with the directions mirrored.
interface fetch_wait_stage_if;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        ready_o;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        cancelled_i;
  logic        exc_i;
  logic        exc_miss_i;
  logic [4:0]  exccode_i;
  logic        commit_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic        exc_miss_o;
  logic [4:0]  exccode_o;
  logic [31:0] perfcnt_fetch_waitdata;
  modport slave (
    input  inst_rdata, inst_data_ok, valid_i, pc_i, cancelled_i, exc_i, exc_miss_i,
           exccode_i, commit_i, ready_i,
    output ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o,
           perfcnt_fetch_waitdata
  );
  modport master (
    output inst_rdata, inst_data_ok, valid_i, pc_i, cancelled_i, exc_i, exc_miss_i,
           exccode_i, commit_i, ready_i,
    input  ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o,
           perfcnt_fetch_waitdata
  );
endinterface

// File: rtl/fetch_wait_stage.sv
// fetch_wait_stage: one-entry IF_wait stage that pairs fetch requests with memory responses.
//   clk, resetn : clock and synchronous active-low reset
//   bus (slave) : fetch entry (valid_i/pc_i/cancelled_i/exc_*), memory response
//                 (inst_rdata/inst_data_ok), flush (commit_i), decode handshake
//                 (ready_i/valid_o), the registered entry, ready_o and the WAIT-cycle counter
module fetch_wait_stage (
  input  logic              clk,
  input  logic              resetn,
  fetch_wait_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, WAIT, HAVE, DROP} state_t;
  state_t state;
  logic   accept;
  logic   flush_pend;
  assign bus.ready_o = state == EMPTY || (state == HAVE && bus.ready_i);
  assign accept = bus.valid_i && bus.ready_o;
  // A flush still owes memory a response if one is outstanding, or if a request goes out this
  // cycle, and that response has not arrived this cycle.
  assign flush_pend = !bus.inst_data_ok &&
                      (state == WAIT || state == DROP || (accept && !bus.exc_i));
  always_ff @(posedge clk)
    if (!resetn) begin
      state                      <= EMPTY;
      bus.valid_o                <= 1'b0;
      bus.pc_o                   <= '0;
      bus.inst_o                 <= '0;
      bus.exc_o                  <= 1'b0;
      bus.exc_miss_o             <= 1'b0;
      bus.exccode_o              <= '0;
      bus.perfcnt_fetch_waitdata <= '0;
    end else begin
      if (state == WAIT && !bus.inst_data_ok)
        bus.perfcnt_fetch_waitdata <= bus.perfcnt_fetch_waitdata + 32'd1;
      if (bus.commit_i) begin
        state       <= flush_pend ? DROP : EMPTY;
        bus.valid_o <= 1'b0;
      end else if (accept) begin
        if (bus.exc_i || !bus.cancelled_i) begin
          bus.pc_o       <= bus.pc_i;
          bus.exc_o      <= bus.exc_i;
          bus.exc_miss_o <= bus.exc_miss_i;
          bus.exccode_o  <= bus.exccode_i;
        end
        if (bus.exc_i) begin
          state       <= HAVE;
          bus.valid_o <= 1'b1;
          bus.inst_o  <= '0;
        end else if (bus.cancelled_i) begin
          state       <= bus.inst_data_ok ? EMPTY : DROP;
          bus.valid_o <= 1'b0;
        end else if (bus.inst_data_ok) begin
          state       <= HAVE;
          bus.valid_o <= 1'b1;
          bus.inst_o  <= bus.inst_rdata;
        end else begin
          state       <= WAIT;
          bus.valid_o <= 1'b0;
        end
      end else if (state == WAIT && bus.inst_data_ok) begin
        state       <= HAVE;
        bus.valid_o <= 1'b1;
        bus.inst_o  <= bus.inst_rdata;
      end else if (state == HAVE && bus.ready_i) begin
        state       <= EMPTY;
        bus.valid_o <= 1'b0;
      end else if (state == DROP && bus.inst_data_ok) begin
        state <= EMPTY;
      end
    end
  // A response with nothing outstanding is ignored by the logic above; flag it in simulation.
  assert property (@(posedge clk) disable iff (!resetn)
    !(bus.inst_data_ok && (state == EMPTY || state == HAVE) && !(accept && !bus.exc_i)))
    else $warning("inst_data_ok with no request outstanding is ignored");
endmodule

// File: tb/tb_fetch_wait_stage.sv
// tb_fetch_wait_stage: directed and randomized check of fetch_wait_stage against a queue-based model.
module tb_fetch_wait_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        miss;
    logic [4:0]  code;
  } ent_t;
  logic clk;
  logic resetn;
  fetch_wait_stage_if bus();
  fetch_wait_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int   ncmp = 0;
  int   nbad = 0;
  bit   have;
  ent_t e;
  ent_t pend;
  bit   q[$];
  logic [31:0] perf;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    ncmp++;
    if (a !== x) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask
  function automatic bit exp_rdy(input logic ri);
    return q.size() == 0 && (!have || ri);
  endfunction
  function automatic ent_t in_ent();
    ent_t t;
    t.pc   = bus.pc_i;
    t.inst = '0;
    t.exc  = bus.exc_i;
    t.miss = bus.exc_miss_i;
    t.code = bus.exccode_i;
    return t;
  endfunction
  task automatic step_model();
    bit acc;
    bit ok;
    ok  = bus.inst_data_ok;
    acc = bus.valid_i && exp_rdy(bus.ready_i);
    if (q.size() != 0 && q[0] && !ok) perf = perf + 32'd1;
    if (bus.commit_i) begin
      have = 0;
      foreach (q[i]) q[i] = 0;
      if (q.size() != 0) begin
        if (ok) void'(q.pop_front());
      end else if (acc && !bus.exc_i && !ok) q.push_back(0);
    end else if (q.size() != 0) begin
      if (ok && q.pop_front()) begin
        have   = 1;
        e      = pend;
        e.inst = bus.inst_rdata;
      end
    end else if (acc) begin
      if (bus.exc_i) begin
        have = 1;
        e    = in_ent();
      end else if (bus.cancelled_i) begin
        have = 0;
        if (!ok) q.push_back(0);
      end else if (ok) begin
        have   = 1;
        e      = in_ent();
        e.inst = bus.inst_rdata;
      end else begin
        have = 0;
        pend = in_ent();
        q.push_back(1);
      end
    end else if (bus.ready_i) have = 0;
  endtask
  task automatic compare();
    chk("valid_o", bus.valid_o, have);
    if (have) begin
      chk("pc_o", bus.pc_o, e.pc);
      chk("inst_o", bus.inst_o, e.inst);
      chk("exc_o", bus.exc_o, e.exc);
      chk("exc_miss_o", bus.exc_miss_o, e.miss);
      chk("exccode_o", bus.exccode_o, e.code);
    end
    chk("perfcnt", bus.perfcnt_fetch_waitdata, perf);
  endtask
  task automatic cyc(input logic v, input logic [31:0] pc, input logic cn, input logic ex,
                     input logic ms, input logic [4:0] code, input logic cm, input logic ri,
                     input logic ok, input logic [31:0] rd);
    bus.valid_i      = v;
    bus.pc_i         = pc;
    bus.cancelled_i  = cn;
    bus.exc_i        = ex;
    bus.exc_miss_i   = ms;
    bus.exccode_i    = code;
    bus.commit_i     = cm;
    bus.ready_i      = ri;
    bus.inst_data_ok = ok;
    bus.inst_rdata   = rd;
    #1 chk("ready_o", bus.ready_o, exp_rdy(ri));
    @(posedge clk);
    step_model();
    @(negedge clk);
    compare();
  endtask
  task automatic idle(input logic ri, input logic ok, input logic [31:0] rd);
    cyc(0, 32'h0, 0, 0, 0, 5'h0, 0, ri, ok, rd);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    bus.valid_i = 0; bus.pc_i = 0; bus.cancelled_i = 0; bus.exc_i = 0; bus.exc_miss_i = 0;
    bus.exccode_i = 0; bus.commit_i = 0; bus.ready_i = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_pc_o", bus.pc_o, 0);
    chk("rst_inst_o", bus.inst_o, 0);
    chk("rst_exc_o", bus.exc_o, 0);
    chk("rst_exc_miss_o", bus.exc_miss_o, 0);
    chk("rst_exccode_o", bus.exccode_o, 0);
    chk("rst_perfcnt", bus.perfcnt_fetch_waitdata, 0);
    chk("rst_ready_o", bus.ready_o, 1);
    have = 0;
    e    = '0;
    pend = '0;
    q.delete();
    perf = '0;
    resetn = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    cyc(1, 32'hBFC00000, 0, 0, 0, 5'h0, 0, 1, 1, 32'h3C1D8000);
    chk("b2b_inst0", bus.inst_o, 32'h3C1D8000);
    cyc(1, 32'hBFC00004, 0, 0, 0, 5'h0, 0, 1, 1, 32'h27BD0010);
    chk("b2b_valid1", bus.valid_o, 1);
    chk("b2b_pc1", bus.pc_o, 32'hBFC00004);
    cyc(1, 32'hBFC00008, 0, 0, 0, 5'h0, 0, 1, 1, 32'h00851021);
    chk("b2b_inst2", bus.inst_o, 32'h00851021);
    idle(1, 0, 0);
    chk("b2b_drain", bus.valid_o, 0);
    chk("b2b_perf", bus.perfcnt_fetch_waitdata, 0);
    do_reset();
    cyc(1, 32'h80001000, 0, 0, 0, 5'h0, 0, 1, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    chk("slow_not_yet", bus.valid_o, 0);
    idle(1, 1, 32'h24020001);
    chk("slow_valid", bus.valid_o, 1);
    chk("slow_inst", bus.inst_o, 32'h24020001);
    chk("slow_perf", bus.perfcnt_fetch_waitdata, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h80001004, 0, 0, 0, 5'h0, 0, 0, 0, 0);
      chk("stall_ready", bus.ready_o, 0);
      chk("stall_pc", bus.pc_o, 32'h80001000);
    end
    cyc(1, 32'h80001004, 0, 0, 0, 5'h0, 0, 1, 1, 32'h24030002);
    chk("stall_next_pc", bus.pc_o, 32'h80001004);
    chk("stall_next_inst", bus.inst_o, 32'h24030002);
    do_reset();
    cyc(1, 32'h80000100, 0, 0, 0, 5'h0, 0, 1, 0, 0);
    cyc(1, 32'h80000104, 0, 0, 0, 5'h0, 1, 1, 0, 0);
    chk("flush_drop_ready", bus.ready_o, 0);
    cyc(1, 32'h80000104, 0, 0, 0, 5'h0, 0, 1, 0, 0);
    chk("flush_still_drop", bus.ready_o, 0);
    cyc(1, 32'h80000104, 0, 0, 0, 5'h0, 0, 1, 1, 32'hDEADBEEF);
    chk("flush_valid", bus.valid_o, 0);
    chk("flush_empty_ready", bus.ready_o, 1);
    do_reset();
    cyc(1, 32'h80000002, 0, 1, 0, 5'h04, 0, 1, 0, 0);
    chk("exc_valid", bus.valid_o, 1);
    chk("exc_flag", bus.exc_o, 1);
    chk("exc_code", bus.exccode_o, 32'h04);
    chk("exc_inst", bus.inst_o, 0);
    idle(0, 1, 32'h12345678);
    chk("exc_stray_inst", bus.inst_o, 0);
    chk("exc_stray_valid", bus.valid_o, 1);
    do_reset();
    cyc(1, 32'h80000200, 1, 0, 0, 5'h0, 0, 1, 1, 32'hCAFEF00D);
    chk("canc_valid", bus.valid_o, 0);
    chk("canc_ready", bus.ready_o, 1);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic v, ex, cn, ri, ok, cm;
      v  = ($urandom % 4) != 0;
      ex = ($urandom % 8) == 0;
      cn = ($urandom % 6) == 0;
      ri = ($urandom % 4) != 0;
      ok = q.size() != 0 ? (($urandom % 3) == 0)
                         : (v && exp_rdy(ri) && !ex && ($urandom % 2) == 1);
      cm = (q.size() == 0 || (q[0] && !ok)) && ($urandom % 12) == 0;
      cyc(v, $urandom, cn, ex, 1'($urandom), 5'($urandom), cm, ri, ok, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
